// File: rtl/mat_reg_sequencer.sv
// mat_reg_sequencer: command sequencer streaming rows/cols of IEEE-754 single words into and out of a MatReg
package mat_reg_pkg;
  typedef enum logic [2:0] {WR_DISABLE, WR_ROW, WR_COL, WR_TRANSPOSE, WR_ZERO} mat_data_write_op_t;
  typedef enum logic [1:0] {RD_DISABLE, RD_ROW, RD_COL} mat_data_read_op_t;
endpackage

module mat_reg_sequencer
  import mat_reg_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic                         cmd_col,
  input  logic [WIDTH_ADDR_SIZE-1:0]   cmd_base,
  input  logic [WIDTH_ADDR_SIZE:0]     cmd_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0][31:0]       in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0][31:0]       out_data,
  output mat_data_write_op_t           mat_write_op,
  output logic [WIDTH_ADDR_SIZE-1:0]   mat_write_p1,
  output mat_data_read_op_t            mat_read_op,
  output logic [WIDTH_ADDR_SIZE-1:0]   mat_read_p1,
  output logic [WIDTH-1:0][31:0]       mat_data_in,
  input  logic [WIDTH-1:0][31:0]       mat_data_out,
  output logic                         busy,
  output logic                         done
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE, OP} state_t;
  localparam logic [WIDTH_ADDR_SIZE-1:0] LAST = WIDTH_ADDR_SIZE'(WIDTH - 1);
  localparam logic [WIDTH_ADDR_SIZE:0] ONE = (WIDTH_ADDR_SIZE + 1)'(1);
  state_t state;
  logic [1:0] op;
  logic col;
  logic [WIDTH_ADDR_SIZE-1:0] idx;
  logic [WIDTH_ADDR_SIZE:0] remaining;
  logic beat;
  assign beat = (state == LOAD && in_valid) || (state == STORE && out_ready);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op <= 2'd0;
      col <= 1'b0;
      idx <= '0;
      remaining <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          op <= cmd_op;
          col <= cmd_col;
          idx <= cmd_base;
          remaining <= cmd_len;
          if (!cmd_op[1] && cmd_len == '0) done <= 1'b1;
          else state <= cmd_op == 2'd0 ? LOAD : cmd_op == 2'd1 ? STORE : OP;
        end
        LOAD, STORE: if (beat) begin
          idx <= idx == LAST ? '0 : idx + 1'b1;
          remaining <= remaining - ONE;
          if (remaining == ONE) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b1;
        end
      endcase
    end
  end
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign in_ready = state == LOAD;
  assign out_valid = state == STORE;
  assign out_data = mat_data_out;
  assign mat_data_in = in_data;
  assign mat_write_p1 = idx;
  assign mat_read_p1 = idx;
  assign mat_write_op = (state == LOAD && in_valid) ? (col ? WR_COL : WR_ROW) :
                        state == OP ? (op == 2'd3 ? WR_ZERO : WR_TRANSPOSE) : WR_DISABLE;
  assign mat_read_op = state == STORE ? (col ? RD_COL : RD_ROW) : RD_DISABLE;
endmodule

// File: tb/tb_mat_reg_sequencer.sv
// tb_mat_reg_sequencer: directed bench with a MatReg environment and a command-level matrix model
module tb_mat_reg_sequencer;
  import mat_reg_pkg::*;
  typedef logic [3:0][31:0] vec_t;
  typedef struct {mat_data_write_op_t op; logic [1:0] p; vec_t d;} wr_t;
  typedef struct {vec_t d; logic [1:0] p;} rd_t;
  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000, F4 = 32'h40800000;

  logic clock = 0, reset = 1, preset = 1;
  logic cmd_valid = 0, cmd_col = 0, in_valid = 0, out_ready = 0;
  logic [1:0] cmd_op = 0, cmd_base = 0;
  logic [2:0] cmd_len = 0;
  vec_t in_data = '0, out_data, mat_data_in, mat_data_out;
  logic cmd_ready, in_ready, out_valid, busy, done;
  mat_data_write_op_t mat_write_op;
  mat_data_read_op_t mat_read_op;
  logic [1:0] mat_write_p1, mat_read_p1;

  int total = 0, bad = 0;
  vec_t em[4];
  vec_t rm[4];
  wr_t exp_wr[$];
  rd_t exp_out[$];

  always #5 clock = ~clock;

  mat_reg_sequencer #(.WIDTH(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mat_write_op(mat_write_op), .mat_write_p1(mat_write_p1),
    .mat_read_op(mat_read_op), .mat_read_p1(mat_read_p1),
    .mat_data_in(mat_data_in), .mat_data_out(mat_data_out),
    .busy(busy), .done(done));

  // MatReg stand-in: combinational read, write on the clock edge
  always @(posedge clock) begin
    if (preset) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) em[i][j] <= 32'h42000000 + 32'(i * 4 + j);
    end else begin
      case (mat_write_op)
        WR_ROW: em[mat_write_p1] <= mat_data_in;
        WR_COL: for (int j = 0; j < 4; j++) em[j][mat_write_p1] <= mat_data_in[j];
        WR_TRANSPOSE: for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) em[i][j] <= em[j][i];
        WR_ZERO: for (int i = 0; i < 4; i++) em[i] <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    mat_data_out = '0;
    if (mat_read_op == RD_ROW) mat_data_out = em[mat_read_p1];
    else if (mat_read_op == RD_COL) for (int j = 0; j < 4; j++) mat_data_out[j] = em[j][mat_read_p1];
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  function automatic vec_t splat(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  function automatic vec_t colv(input logic [1:0] p);
    vec_t v;
    for (int j = 0; j < 4; j++) v[j] = rm[j][p];
    return v;
  endfunction

  // every cycle: MatReg writes and STORE beats must match the queued model expectations
  always @(negedge clock) begin
    if (!reset) begin
      if (mat_write_op != WR_DISABLE) begin
        if (exp_wr.size() == 0) fail_now("unexpected write");
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("write op", 128'(mat_write_op), 128'(e.op));
          if (e.op == WR_ROW || e.op == WR_COL) begin
            chk("write index", 128'(mat_write_p1), 128'(e.p));
            chk("write data", mat_data_in, e.d);
          end
        end
      end
      if (out_valid) begin
        if (exp_out.size() == 0) fail_now("unexpected store beat");
        else begin
          chk("store data", out_data, exp_out[0].d);
          chk("store index", 128'(mat_read_p1), 128'(exp_out[0].p));
          if (out_ready) void'(exp_out.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic c, input logic [1:0] b, input logic [2:0] l);
    int n = 0;
    cmd_valid = 1; cmd_op = op; cmd_col = c; cmd_base = b; cmd_len = l;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (n == 20) fail_now("command accept timeout");
    tick();
    cmd_valid = 0;
  endtask

  task automatic load(input logic c, input logic [1:0] b, input logic [2:0] l, input int nb, input int gap, input vec_t d[4]);
    issue(2'd0, c, b, l);
    for (int k = 0; k < nb; k++) begin
      logic [1:0] p;
      p = b + 2'(k);
      repeat (gap) tick();
      in_valid = 1;
      in_data = d[k];
      exp_wr.push_back('{c ? WR_COL : WR_ROW, p, d[k]});
      if (c) for (int j = 0; j < 4; j++) rm[j][p] = d[k][j];
      else rm[p] = d[k];
      chk("in_ready in load", 128'(in_ready), 128'(1));
      tick();
      in_valid = 0;
    end
    if (nb == int'(l)) begin
      chk("load done", 128'(done), 128'(1));
      chk("load idle", 128'(busy), 128'(0));
    end
  endtask

  task automatic push_store(input logic c, input logic [1:0] b, input logic [2:0] l);
    for (int k = 0; k < int'(l); k++) begin
      logic [1:0] p;
      p = b + 2'(k);
      exp_out.push_back('{c ? colv(p) : rm[p], p});
    end
  endtask

  task automatic store_beats(input int l, input int stall_beat, input int stall_n);
    int got = 0, n = 0, s = stall_n;
    while (got < l && n < 100) begin
      out_ready = !(got == stall_beat && s > 0);
      if (!out_ready) s--;
      if (out_valid && out_ready) got++;
      tick();
      n++;
    end
    out_ready = 0;
    if (got < l) fail_now("store beat timeout");
    chk("store done", 128'(done), 128'(1));
    chk("store idle", 128'(out_valid), 128'(0));
    chk("store beats consumed", 128'(exp_out.size()), 128'(0));
  endtask

  task automatic store(input logic c, input logic [1:0] b, input logic [2:0] l, input int stall_beat, input int stall_n);
    push_store(c, b, l);
    issue(2'd1, c, b, l);
    store_beats(int'(l), stall_beat, stall_n);
  endtask

  task automatic transpose();
    vec_t t[4];
    exp_wr.push_back('{WR_TRANSPOSE, 2'd0, '0});
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) t[i][j] = rm[j][i];
    rm = t;
    issue(2'd2, 1'b0, 2'd0, 3'd0);
    tick();
    chk("transpose done", 128'(done), 128'(1));
  endtask

  task automatic check_mat(input string nm);
    for (int i = 0; i < 4; i++) chk(nm, em[i], rm[i]);
  endtask

  initial begin
    vec_t d[4];
    repeat (3) tick();
    preset = 0;
    reset = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) rm[i][j] = 32'h42000000 + 32'(i * 4 + j);
    chk("reset cmd_ready", 128'(cmd_ready), 128'(1));
    chk("reset in_ready", 128'(in_ready), 128'(0));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset write_op", 128'(mat_write_op), 128'(WR_DISABLE));
    chk("reset read_op", 128'(mat_read_op), 128'(RD_DISABLE));

    // ZERO then STORE len=4 under continuous cmd_valid
    exp_wr.push_back('{WR_ZERO, 2'd0, '0});
    cmd_valid = 1; cmd_op = 2'd3; cmd_col = 0; cmd_base = 0; cmd_len = 3'd4;
    tick();
    for (int i = 0; i < 4; i++) rm[i] = '0;
    chk("pin zero model", rm[2], 128'h0);
    cmd_op = 2'd1;
    push_store(1'b0, 2'd0, 3'd4);
    chk("busy during op", 128'(busy), 128'(1));
    chk("cmd_ready during op", 128'(cmd_ready), 128'(0));
    tick();
    chk("zero done", 128'(done), 128'(1));
    chk("accept in done cycle", 128'(cmd_ready), 128'(1));
    tick();
    cmd_valid = 0;
    store_beats(4, 9, 0);

    // rows of constants, transposed, read back
    for (int r = 0; r < 4; r++) d[r] = splat(r == 0 ? F1 : r == 1 ? F2 : r == 2 ? F3 : F4);
    load(1'b0, 2'd0, 3'd4, 4, 0, d);
    transpose();
    chk("pin transpose model", rm[2], {F4, F3, F2, F1});
    store(1'b0, 2'd0, 3'd4, 9, 0);

    // column load wrapping from col 3 to col 0
    d[0] = splat(32'h41000000);
    d[1] = splat(32'h41100000);
    load(1'b1, 2'd3, 3'd2, 2, 0, d);
    chk("pin col wrap model", rm[1], {32'h41000000, F3, F2, 32'h41100000});
    store(1'b1, 2'd0, 3'd4, 9, 0);
    check_mat("matrix after col load");

    // back-pressure on the second beat
    store(1'b0, 2'd1, 3'd3, 1, 2);

    // reset after two of four gapped beats
    d[0] = splat(32'h41200000);
    d[1] = splat(32'h41300000);
    load(1'b0, 2'd0, 3'd4, 2, 1, d);
    reset = 1;
    tick();
    reset = 0;
    chk("abort idle", 128'(busy), 128'(0));
    chk("abort no done", 128'(done), 128'(0));
    chk("abort cmd_ready", 128'(cmd_ready), 128'(1));
    tick();
    chk("abort no late done", 128'(done), 128'(0));
    check_mat("matrix after abort");

    // zero-length load
    issue(2'd0, 1'b0, 2'd2, 3'd0);
    chk("len0 done", 128'(done), 128'(1));
    chk("len0 idle", 128'(busy), 128'(0));
    tick();
    check_mat("matrix after len0");
    chk("writes consumed", 128'(exp_wr.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
